pattern_serializer: RTL and testbench

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

---
 rtl/pattern_serializer.sv | 108 ++++++++++
 tb/tb_pattern_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer so that words
// can be streamed back-to-back with no idle cycle between them.
module pattern_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] buf_q, shreg;
  logic             buf_full, buf_full_d;
  logic [CW-1:0]    cnt;
  logic             accept, load, last;
  logic             seq_d, bv_d, wd_d, busy_d;
  logic             first_bit, shift_bit;

  assign accept    = data_valid & data_ready;
  assign last      = (cnt == CW'(WIDTH-1));
  assign first_bit = MSB_FIRST ? buf_q[WIDTH-1] : buf_q[0];
  assign shift_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: if (buf_full) begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (last) begin
        if (buf_full) load = 1'b1;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the output flops; outputs reflect the cycle after the edge.
  always_comb begin
    buf_full_d = accept | (buf_full & ~load);
    seq_d      = IDLE_LEVEL;
    bv_d       = 1'b0;
    wd_d       = 1'b0;
    if (load) begin
      seq_d = first_bit;
      bv_d  = 1'b1;
    end else if (state_d == SHIFT) begin
      seq_d = shift_bit;
      bv_d  = 1'b1;
      wd_d  = (cnt == CW'(WIDTH-2));
    end
    busy_d = (state_d == SHIFT) | buf_full_d;
  end

  // shreg holds only the bits not yet presented on sequence_out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
    end else begin
      buf_full <= buf_full_d;
      if (accept) buf_q <= data_in;
      if (load) begin
        shreg <= MSB_FIRST ? (buf_q << 1) : (buf_q >> 1);
        cnt   <= '0;
      end else if (state == SHIFT) begin
        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        cnt   <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sequence_out <= IDLE_LEVEL;
      bit_valid    <= 1'b0;
      word_done    <= 1'b0;
      busy         <= 1'b0;
      data_ready   <= 1'b1;
    end else begin
      sequence_out <= seq_d;
      bit_valid    <= bv_d;
      word_done    <= wd_d;
      busy         <= busy_d;
      data_ready   <= ~buf_full_d;
    end
  end
endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench: drivers push expected bits, negedge monitors pop and compare.
module tb_pattern_serializer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, sequence_out, bit_valid, word_done, busy;

  logic [7:0] l_data = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_seq, l_bv, l_wd, l_busy;

  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       i_ready, i_seq, i_bv, i_wd, i_busy;

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(0)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .sequence_out(sequence_out), .bit_valid(bit_valid),
    .word_done(word_done), .busy(busy));

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0)) dut_lsb (
    .clock(clock), .reset(reset), .data_in(l_data), .data_valid(l_valid),
    .data_ready(l_ready), .sequence_out(l_seq), .bit_valid(l_bv),
    .word_done(l_wd), .busy(l_busy));

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1)) dut_idle (
    .clock(clock), .reset(reset), .data_in(i_data), .data_valid(i_valid),
    .data_ready(i_ready), .sequence_out(i_seq), .bit_valid(i_bv),
    .word_done(i_wd), .busy(i_busy));

  typedef struct packed { logic b; logic last; } exp_t;
  exp_t q[$];
  exp_t lq[$];
  exp_t e, le;
  int   done_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run = 0, last_run = 0, first_cyc = 0, bv_total = 0, idle_n = 0;
  int acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main monitor: every valid bit is checked against the scoreboard head.
  always @(negedge clock) begin
    if (bit_valid === 1'b1) begin
      if (run == 0) first_cyc = cyc;
      run++;
      bv_total++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bit actual=%0b expected=none (t=%0t)", sequence_out, $time);
      end else begin
        e = q.pop_front();
        chk("seq_bit", sequence_out, e.b);
        chk("word_done", word_done, e.last);
        if (word_done) done_cyc.push_back(cyc);
      end
    end else begin
      if (run > 0) begin last_run = run; run = 0; end
      chk("idle_seq", sequence_out, 1'b0);
      chk("idle_done", word_done, 1'b0);
    end
  end

  always @(negedge clock) begin
    if (l_bv === 1'b1) begin
      if (lq.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb_unexpected_bit actual=%0b expected=none (t=%0t)", l_seq, $time);
      end else begin
        le = lq.pop_front();
        chk("lsb_bit", l_seq, le.b);
        chk("lsb_done", l_wd, le.last);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && idle_n < 20) begin
      idle_n++;
      chk("idle_lvl_seq", i_seq, 1'b1);
      chk("idle_lvl_bv", i_bv, 1'b0);
      chk("idle_lvl_busy", i_busy, 1'b0);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with
  // data_valid still high so the caller can chain another word.
  task automatic send(input logic [7:0] w, output int waited);
    logic r;
    waited = 0;
    data_in = w;
    data_valid = 1'b1;
    while (1) begin
      r = data_ready;
      @(posedge clock);
      if (r) break;
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=%0d expected<=200", waited);
        break;
      end
      @(negedge clock);
    end
    for (int i = 7; i >= 0; i--) q.push_back('{b: w[i], last: (i == 0)});
    @(negedge clock);
    acc_cyc = cyc;
  endtask

  int w1, w2, w3, bv_snap;

  initial begin
    #2 reset = 1'b0;
    #2;
    chk("rst_ready", data_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bv", bit_valid, 1'b0);
    chk("rst_seq", sequence_out, 1'b0);
    chk("rst_idle_seq", i_seq, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Idle accept, latency and single word_done
    @(negedge clock);
    send(8'hB0, w1);
    data_valid = 1'b0;
    chk("acc_ready_low", data_ready, 1'b0);
    chk("acc_busy", busy, 1'b1);
    repeat (12) @(negedge clock);
    chk("latency", first_cyc - acc_cyc, 1);
    chk("run_b0", last_run, 8);
    chk("done_count_b0", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("done_pos_b0", done_cyc[0] - acc_cyc, 8);
    done_cyc.delete();

    // Back-to-back: second word accepted while busy, no gap
    send(8'hB5, w1);
    send(8'h5A, w2);
    data_valid = 1'b0;
    chk("b2b_wait", w2, 1);
    repeat (24) @(negedge clock);
    chk("b2b_run", last_run, 16);
    chk("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_done_gap", done_cyc[1] - done_cyc[0], 8);
    done_cyc.delete();

    // Backpressure with data_valid held high across three words
    send(8'h11, w1);
    send(8'hE7, w2);
    send(8'h3C, w3);
    data_valid = 1'b0;
    chk("bp_wait2", w2, 1);
    chk("bp_wait3", w3, 7);
    repeat (30) @(negedge clock);
    chk("bp_run", last_run, 24);
    done_cyc.delete();

    // Reset during bit index 3 of 8'hFF with 8'h33 buffered
    send(8'hFF, w1);
    send(8'h33, w2);
    data_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_bv", bit_valid, 1'b0);
    chk("mid_rst_seq", sequence_out, 1'b0);
    chk("mid_rst_done", word_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", data_ready, 1'b1);
    q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    bv_snap = bv_total;
    repeat (15) @(negedge clock);
    chk("post_rst_no_bits", bv_total, bv_snap);
    chk("post_rst_busy", busy, 1'b0);
    send(8'hA5, w1);
    data_valid = 1'b0;
    repeat (12) @(negedge clock);
    chk("post_rst_run", last_run, 8);

    // LSB-first instance
    chk("lsb_ready", l_ready, 1'b1);
    l_data = 8'h0D;
    l_valid = 1'b1;
    for (int i = 0; i < 8; i++) lq.push_back('{b: l_data[i], last: (i == 7)});
    @(negedge clock);
    l_valid = 1'b0;
    repeat (12) @(negedge clock);

    chk("q_drained", q.size(), 0);
    chk("lq_drained", lq.size(), 0);
    chk("idle_window", idle_n, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
